lenet_sequencer: RTL and testbench

- Accelerator-side responder for the LeNet start handshake; consumes the one-cycle lenet_go pulse and drives lenet_ready back to the go generator.
- Sequences the LeNet layer engines in order (conv1, pool1, conv2, pool2, fc1, fc2, fc3) with start/done handshakes and a per-layer watchdog.
- Latches the classification result.
- Sits between the go generator and the layer compute engines.

---
 rtl/lenet_sequencer.sv | 166 ++++++++++++++++
 tb/tb_lenet_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lenet_sequencer.sv
// LeNet layer sequencer: answers the go handshake and starts the seven layer
// engines one after another. Each layer has a watchdog, and the final class
// index is latched. Every output comes straight from a flop.
module lenet_sequencer #(
  parameter int                NUM_LAYERS = 7,
  parameter int                CLASS_W    = 4,
  parameter int                TMO_W      = 20,
  parameter logic [TMO_W-1:0]  TIMEOUT    = 20'd1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lenet_go,
  output logic                  lenet_ready,
  output logic                  busy,
  output logic [NUM_LAYERS-1:0] layer_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  input  logic [CLASS_W-1:0]    class_in,
  output logic [CLASS_W-1:0]    result,
  output logic                  result_valid,
  output logic                  timeout_err,
  input  logic                  err_clr
);

  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);
  // Watchdog fires when the counter has reached this value without a done.
  localparam logic [TMO_W-1:0] WD_LAST = TIMEOUT - TMO_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      layer_idx_q, layer_idx_d;
  logic [TMO_W-1:0]      wd_cnt_q, wd_cnt_d;
  logic                  lenet_ready_q, lenet_ready_d;
  logic                  busy_q, busy_d;
  logic [NUM_LAYERS-1:0] layer_start_q, layer_start_d;
  logic [CLASS_W-1:0]    result_q, result_d;
  logic                  result_valid_q, result_valid_d;
  logic                  timeout_err_q, timeout_err_d;

  logic                  done_active;
  logic                  done_seen;
  logic                  timeout_set;
  logic [NUM_LAYERS-1:0] next_onehot;

  // Select the done bit of the active layer and the one-hot start for the next one.
  always_comb begin
    done_active = 1'b0;
    next_onehot = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (layer_idx_q == IDX_W'(i)) begin
        done_active = layer_done[i];
      end
      if (layer_idx_q + IDX_W'(1) == IDX_W'(i)) begin
        next_onehot[i] = 1'b1;
      end
    end
    // A done level that is already present while the start pulse is high is
    // stale and must not advance the sequence.
    done_seen = done_active && (layer_start_q == '0);
  end

  // Next-state and output logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d        = state_q;
    layer_idx_d    = layer_idx_q;
    wd_cnt_d       = wd_cnt_q;
    lenet_ready_d  = lenet_ready_q;
    busy_d         = busy_q;
    layer_start_d  = '0;
    result_d       = result_q;
    result_valid_d = 1'b0;
    timeout_set    = 1'b0;

    case (state_q)
      S_IDLE: begin
        lenet_ready_d = 1'b1;
        busy_d        = 1'b0;
        if (lenet_go) begin
          state_d       = S_RUN;
          layer_idx_d   = '0;
          layer_start_d = NUM_LAYERS'(1);
          wd_cnt_d      = '0;
          lenet_ready_d = 1'b0;
          busy_d        = 1'b1;
        end
      end
      S_RUN: begin
        if (done_seen) begin
          if (layer_idx_q == LAST_IDX) begin
            result_d       = class_in;
            result_valid_d = 1'b1;
            state_d        = S_DONE;
          end else begin
            layer_idx_d   = layer_idx_q + IDX_W'(1);
            layer_start_d = next_onehot;
            wd_cnt_d      = '0;
          end
        end else if (wd_cnt_q == WD_LAST) begin
          timeout_set    = 1'b1;
          result_d       = '1;
          result_valid_d = 1'b1;
          state_d        = S_DONE;
        end else begin
          wd_cnt_d = wd_cnt_q + TMO_W'(1);
        end
      end
      S_DONE: begin
        state_d       = S_IDLE;
        lenet_ready_d = 1'b1;
        busy_d        = 1'b0;
      end
      default: begin
        state_d       = S_IDLE;
        lenet_ready_d = 1'b1;
        busy_d        = 1'b0;
      end
    endcase

    // A new expiry outranks a clear arriving in the same cycle.
    if (timeout_set) begin
      timeout_err_d = 1'b1;
    end else if (err_clr) begin
      timeout_err_d = 1'b0;
    end else begin
      timeout_err_d = timeout_err_q;
    end
  end

  // State and output registers, asynchronously reset to the idle state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      layer_idx_q    <= '0;
      wd_cnt_q       <= '0;
      lenet_ready_q  <= 1'b1;
      busy_q         <= 1'b0;
      layer_start_q  <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      layer_idx_q    <= layer_idx_d;
      wd_cnt_q       <= wd_cnt_d;
      lenet_ready_q  <= lenet_ready_d;
      busy_q         <= busy_d;
      layer_start_q  <= layer_start_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign lenet_ready  = lenet_ready_q;
  assign busy         = busy_q;
  assign layer_start  = layer_start_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_lenet_sequencer.sv
// Bench for lenet_sequencer: directed runs with randomized engine latencies,
// class values and spurious done/go activity, checked cycle by cycle against a
// schedule computed from the handshake timing rules.
module tb_lenet_sequencer;

  localparam int TMO = 16;

  logic       clk;
  logic       rst_n;
  logic       lenet_go;
  logic       lenet_ready;
  logic       busy;
  logic [6:0] layer_start;
  logic [6:0] layer_done;
  logic [3:0] class_in;
  logic [3:0] result;
  logic       result_valid;
  logic       timeout_err;
  logic       err_clr;

  int         total = 0;
  int         bad = 0;
  int         vcount = 0;
  int         v0;
  int         d_arr[7];
  logic [3:0] result_exp;
  logic       err_exp;

  lenet_sequencer #(
    .NUM_LAYERS(7),
    .CLASS_W   (4),
    .TMO_W     (20),
    .TIMEOUT   (20'd16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lenet_go    (lenet_go),
    .lenet_ready (lenet_ready),
    .busy        (busy),
    .layer_start (layer_start),
    .layer_done  (layer_done),
    .class_in    (class_in),
    .result      (result),
    .result_valid(result_valid),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count result_valid pulses independently of the per-cycle checks.
  always @(posedge clk) begin
    if (result_valid === 1'b1) vcount <= vcount + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One run starting with a go pulse in the current cycle (relative cycle 0).
  // hang: layer that never answers (-1 none). clr_at: cycle for err_clr
  // (-1 none, -2 the watchdog set cycle). abort_c: cycle to assert reset.
  task automatic run(input int hang, input logic [3:0] cls, input bit stale,
                     input bit noisy, input int clr_at, input int abort_c);
    int s[7];
    int dn[7];
    int t, vc, nlay, act, clr_c;
    bit tmo;
    logic [6:0] st_exp;
    logic [6:0] dv;
    t = 1; tmo = 0; vc = 0; nlay = 0;
    for (int k = 0; k < 7; k++) begin
      s[k] = t;
      dn[k] = 0;
      nlay = k + 1;
      if (k == hang) begin
        tmo = 1;
        vc = t + TMO;
        break;
      end
      dn[k] = t + d_arr[k];
      t = dn[k] + 1;
    end
    if (!tmo) vc = t;
    clr_c = (clr_at == -2) ? vc - 1 : clr_at;
    $display("run: hang=%0d cls=%0h stale=%0d noisy=%0d valid_at=%0d timeout=%0d",
             hang, cls, stale, noisy, vc, tmo);
    for (int c = 0; c <= vc + 1; c++) begin
      st_exp = '0;
      act = -1;
      for (int k = 0; k < nlay; k++) begin
        if (s[k] == c) st_exp[k] = 1'b1;
        if (c >= s[k] && c < vc) act = k;
      end
      chk("layer_start", 32'(layer_start), 32'(st_exp));
      chk("result_valid", 32'(result_valid), 32'(c == vc));
      chk("lenet_ready", 32'(lenet_ready), 32'((c == 0) || (c > vc)));
      chk("busy", 32'(busy), 32'((c >= 1) && (c <= vc)));
      chk("result", 32'(result), 32'(result_exp));
      chk("timeout_err", 32'(timeout_err), 32'(err_exp));
      if (c == abort_c) begin
        rst_n = 1'b0;
        return;
      end
      if (c == 0) lenet_go = 1'b1;
      else if (noisy && c <= vc) lenet_go = 1'($urandom_range(0, 1));
      else lenet_go = 1'b0;
      err_clr = (c == clr_c);
      class_in = (!tmo && c == dn[6]) ? cls : 4'($urandom);
      dv = stale ? 7'h7f : 7'($urandom);
      if (act >= 0) dv[act] = ((act != hang) && (c == dn[act])) || (stale && (c == s[act]));
      layer_done = dv;
      if (c == vc - 1) result_exp = tmo ? 4'hF : cls;
      if (tmo && c == vc - 1) err_exp = 1'b1;
      else if (c == clr_c) err_exp = 1'b0;
      @(posedge clk);
      #1;
    end
    lenet_go = 1'b0;
    err_clr = 1'b0;
    layer_done = '0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 32'(lenet_ready), 32'(1));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_start"}, 32'(layer_start), 32'(0));
    chk({tag, "_result"}, 32'(result), 32'(0));
    chk({tag, "_valid"}, 32'(result_valid), 32'(0));
    chk({tag, "_err"}, 32'(timeout_err), 32'(0));
  endtask

  initial begin
    rst_n = 1'b0; lenet_go = 1'b0; layer_done = '0; class_in = '0; err_clr = 1'b0;
    result_exp = '0; err_exp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_idle("reset");
    repeat (8) @(posedge clk);
    #1;

    // Nominal run: every engine answers 5 cycles after its start.
    for (int k = 0; k < 7; k++) d_arr[k] = 5;
    run(-1, 4'd7, 0, 0, -1, -1);

    // Random engine latencies and class values.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 7; k++) d_arr[k] = $urandom_range(1, 8);
      run(-1, 4'($urandom), 0, 0, -1, -1);
    end

    // Foreign done bits held high, active bit high during its start cycle.
    for (int k = 0; k < 7; k++) d_arr[k] = $urandom_range(2, 6);
    run(-1, 4'($urandom), 1, 0, -1, -1);

    // Engine 2 never answers; err_clr in the set cycle loses to the set.
    for (int k = 0; k < 7; k++) d_arr[k] = 5;
    run(2, 4'h3, 0, 0, -2, -1);

    // Sticky error does not block the next run.
    for (int k = 0; k < 7; k++) d_arr[k] = $urandom_range(1, 6);
    run(-1, 4'($urandom), 0, 1, -1, -1);

    // Clear the sticky error.
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    err_exp = 1'b0;
    chk("err_clr", 32'(timeout_err), 32'(err_exp));
    $display("err_clr pulse: timeout_err=%0d", timeout_err);

    // Done arrives exactly on the last watchdog cycle; go pulses mid-run ignored.
    for (int k = 0; k < 7; k++) d_arr[k] = TMO - 1;
    run(-1, 4'($urandom), 0, 1, -1, -1);

    // Ten back-to-back runs.
    v0 = vcount;
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 7; k++) d_arr[k] = $urandom_range(1, 6);
      run(-1, 4'($urandom), r[0], 1, -1, -1);
    end
    chk("valid_count", 32'(vcount - v0), 32'(10));

    // Reset while layer 3 is active.
    for (int k = 0; k < 7; k++) d_arr[k] = 3;
    v0 = vcount;
    run(-1, 4'd5, 0, 0, -1, 14);
    lenet_go = 1'b0; err_clr = 1'b0; layer_done = '0;
    result_exp = '0; err_exp = 1'b0;
    #1;
    chk_idle("abort");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk_idle("post_abort");
      @(posedge clk);
      #1;
    end
    chk("abort_no_valid", 32'(vcount - v0), 32'(0));

    for (int k = 0; k < 7; k++) d_arr[k] = $urandom_range(1, 6);
    run(-1, 4'($urandom), 0, 0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
